// File: rtl/j1_dbus_uart_tx_if.sv
// J1 data bus: the master drives address, strobes and write data.
// Each responder returns read data on dat_i, which is zero while it is not answering.
interface if_dbus;
    logic [15:0] adr;
    logic        re;
    logic        we;
    logic [15:0] dat_o;
    logic [15:0] dat_i;

    modport master (output adr, output re, output we, output dat_o, input dat_i);
    modport slave  (input adr, input re, input we, input dat_o, output dat_i);
endinterface

// File: rtl/j1_dbus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the J1 data bus.
// A transmit FIFO feeds a serializer that runs at BAUDDIV+1 clocks per bit.
module j1_dbus_uart_tx #(
    parameter logic [15:0] BASE_ADR   = 16'h3800,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] BAUD_RST   = 16'd433
) (
    input  logic  clk,
    input  logic  reset,
    if_dbus.slave dbus,
    output logic  txd,
    output logic  irq
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          r_state;
    logic [15:0]     r_baud;
    logic [15:0]     r_bitCnt;
    logic [2:0]      r_bitIdx;
    logic [7:0]      r_shift;
    logic            r_txd;
    logic            r_irq;
    logic            r_overflow;
    logic [15:0]     r_datI;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wrPtr;
    logic [AW-1:0]   r_rdPtr;
    logic [CW-1:0]   r_count;

    logic            w_hit;
    logic            w_rd;
    logic            w_wr;
    logic            w_empty;
    logic            w_full;
    logic            w_bitEnd;
    logic            w_pop;
    logic            w_wrTx;
    logic            w_push;
    logic            w_drop;
    logic [15:0]     w_status;
    logic [15:0]     w_rdVal;

    assign w_hit    = (dbus.adr[15:2] == BASE_ADR[15:2]);
    assign w_rd     = dbus.re && w_hit;
    assign w_wr     = dbus.we && w_hit;
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(FIFO_DEPTH));
    assign w_bitEnd = (r_bitCnt == 16'd0);

    // The serializer pops either from idle or at the end of a stop bit for back-to-back frames.
    assign w_pop    = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_bitEnd));
    assign w_wrTx   = w_wr && (dbus.adr[1:0] == 2'd0);
    assign w_push   = w_wrTx && (!w_full || w_pop);
    assign w_drop   = w_wrTx && !w_push;

    assign w_status = {1'b0, 7'(r_count), 4'b0000, r_overflow, w_empty, w_full, (r_state != IDLE)};

    always_comb begin
        w_rdVal = 16'h0000;
        case (dbus.adr[1:0])
            2'd1:    w_rdVal = w_status;
            2'd2:    w_rdVal = r_baud;
            default: w_rdVal = 16'h0000;
        endcase
    end

    // Register file and read port; dat_i only carries data in the cycle after a hitting read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_baud     <= BAUD_RST;
            r_datI     <= 16'h0000;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr && (dbus.adr[1:0] == 2'd2)) begin
                r_baud <= dbus.dat_o;
            end
            r_datI <= w_rd ? w_rdVal : 16'h0000;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_rd && (dbus.adr[1:0] == 2'd1)) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= dbus.dat_o[7:0];
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Bit counter reloads from r_baud only at bit boundaries, so divider writes never disturb a bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_bitCnt <= 16'd0;
            r_bitIdx <= 3'd0;
            r_shift  <= 8'h00;
            r_txd    <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_txd <= 1'b1;
                    if (w_pop) begin
                        r_shift  <= r_mem[r_rdPtr];
                        r_bitCnt <= r_baud;
                        r_txd    <= 1'b0;
                        r_state  <= START;
                    end
                end
                START: begin
                    if (w_bitEnd) begin
                        r_bitCnt <= r_baud;
                        r_bitIdx <= 3'd0;
                        r_txd    <= r_shift[0];
                        r_state  <= DATA;
                    end else begin
                        r_bitCnt <= r_bitCnt - 16'd1;
                    end
                end
                DATA: begin
                    if (w_bitEnd) begin
                        r_bitCnt <= r_baud;
                        if (r_bitIdx == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_shift  <= r_shift >> 1;
                            r_txd    <= r_shift[1];
                            r_bitIdx <= r_bitIdx + 3'd1;
                        end
                    end else begin
                        r_bitCnt <= r_bitCnt - 16'd1;
                    end
                end
                STOP: begin
                    if (w_bitEnd) begin
                        if (w_pop) begin
                            r_shift  <= r_mem[r_rdPtr];
                            r_bitCnt <= r_baud;
                            r_txd    <= 1'b0;
                            r_state  <= START;
                        end else begin
                            r_txd   <= 1'b1;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_bitCnt <= r_bitCnt - 16'd1;
                    end
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq <= 1'b1;
        end else begin
            r_irq <= w_empty && (r_state == IDLE);
        end
    end

    assign dbus.dat_i = r_datI;
    assign txd        = r_txd;
    assign irq        = r_irq;

endmodule

// File: tb/tb_j1_dbus_uart_tx.sv
// Directed bench for j1_dbus_uart_tx: a register-access vector table
// followed by hand-written serial-timing, overflow, miss and reset sequences.
module tb_j1_dbus_uart_tx;

    localparam logic [15:0] A_TX   = 16'h3800;
    localparam logic [15:0] A_STAT = 16'h3801;
    localparam logic [15:0] A_BAUD = 16'h3802;
    localparam logic [15:0] A_RSV  = 16'h3803;
    localparam logic [15:0] A_MISS = 16'h3804;

    typedef struct {
        logic        re;
        logic        we;
        logic [15:0] adr;
        logic [15:0] wdat;
        logic [15:0] expDat;
        string       name;
    } vec_t;

    logic   clk;
    logic   reset;
    logic   txd;
    logic   irq;
    if_dbus dbus ();

    int     testsRun;
    int     testsFailed;
    vec_t   vecs [11];

    j1_dbus_uart_tx #(
        .BASE_ADR   (16'h3800),
        .FIFO_DEPTH (16),
        .BAUD_RST   (16'd433)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .dbus  (dbus),
        .txd   (txd),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds the strobes for one cycle; returns one step into the following cycle.
    task automatic applyStimulus(input logic re, input logic we, input logic [15:0] adr,
                                 input logic [15:0] wdat);
        dbus.re    = re;
        dbus.we    = we;
        dbus.adr   = adr;
        dbus.dat_o = wdat;
        tick();
        dbus.re    = 1'b0;
        dbus.we    = 1'b0;
        dbus.adr   = 16'h0000;
        dbus.dat_o = 16'h0000;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    function automatic logic frameBit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        dbus.re     = 1'b0;
        dbus.we     = 1'b0;
        dbus.adr    = 16'h0000;
        dbus.dat_o  = 16'h0000;
        reset       = 1'b1;

        vecs[0]  = '{1'b1, 1'b0, A_STAT, 16'h0000, 16'h0004, "rd_status_rst"};
        vecs[1]  = '{1'b1, 1'b0, A_BAUD, 16'h0000, 16'd433,  "rd_baud_rst"};
        vecs[2]  = '{1'b1, 1'b0, A_RSV,  16'h0000, 16'h0000, "rd_reserved"};
        vecs[3]  = '{1'b1, 1'b0, A_TX,   16'h0000, 16'h0000, "rd_txdata"};
        vecs[4]  = '{1'b0, 1'b1, A_BAUD, 16'h0003, 16'h0000, "wr_baud3"};
        vecs[5]  = '{1'b1, 1'b0, A_BAUD, 16'h0000, 16'h0003, "rd_baud3"};
        vecs[6]  = '{1'b1, 1'b0, A_MISS, 16'h0000, 16'h0000, "rd_miss"};
        vecs[7]  = '{1'b0, 1'b1, A_RSV,  16'h1234, 16'h0000, "wr_reserved"};
        vecs[8]  = '{1'b1, 1'b1, A_BAUD, 16'h00AB, 16'h0003, "rdwr_baud_old"};
        vecs[9]  = '{1'b1, 1'b1, A_BAUD, 16'h0003, 16'h00AB, "rdwr_baud_new"};
        vecs[10] = '{1'b1, 1'b0, A_BAUD, 16'h0000, 16'h0003, "rd_baud_back3"};

        applyReset();
        checkOutput("rst_txd",  {15'h0, txd}, 16'h0001);
        checkOutput("rst_irq",  {15'h0, irq}, 16'h0001);
        checkOutput("rst_dati", dbus.dat_i,   16'h0000);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].re, vecs[i].we, vecs[i].adr, vecs[i].wdat);
            checkOutput(vecs[i].name, dbus.dat_i, vecs[i].expDat);
            tick();
            checkOutput({vecs[i].name, "_after"}, dbus.dat_i, 16'h0000);
        end
        checkOutput("idle_txd", {15'h0, txd}, 16'h0001);

        // Single 0x55 frame at four clocks per bit.
        applyStimulus(1'b0, 1'b1, A_TX, 16'h0055);
        checkOutput("lat_n1_txd", {15'h0, txd}, 16'h0001);
        tick();
        for (int k = 0; k < 40; k++) begin
            checkOutput($sformatf("f55_c%0d", k), {15'h0, txd}, {15'h0, frameBit(8'h55, k / 4)});
            if (k == 20) checkOutput("f55_irq_busy", {15'h0, irq}, 16'h0000);
            tick();
        end
        checkOutput("f55_end_txd", {15'h0, txd}, 16'h0001);
        tick();
        tick();
        checkOutput("f55_end_irq", {15'h0, irq}, 16'h0001);

        // Back-to-back frames at one clock per bit.
        applyStimulus(1'b0, 1'b1, A_BAUD, 16'h0000);
        applyStimulus(1'b0, 1'b1, A_TX,   16'h0000);
        applyStimulus(1'b0, 1'b1, A_TX,   16'h00FF);
        for (int k = 0; k < 20; k++) begin
            checkOutput($sformatf("b2b_c%0d", k), {15'h0, txd},
                        {15'h0, (k < 10) ? frameBit(8'h00, k) : frameBit(8'hFF, k - 10)});
            tick();
        end
        checkOutput("b2b_end_txd", {15'h0, txd}, 16'h0001);
        tick();
        tick();
        checkOutput("b2b_end_irq", {15'h0, irq}, 16'h0001);

        // Eighteen writes: one popped, sixteen queued, one dropped.
        applyStimulus(1'b0, 1'b1, A_BAUD, 16'd100);
        for (int j = 0; j < 18; j++) begin
            applyStimulus(1'b0, 1'b1, A_TX, 16'(j + 16'h0030));
        end
        applyStimulus(1'b1, 1'b0, A_STAT, 16'h0000);
        checkOutput("ovf_status1", dbus.dat_i, 16'h100B);
        applyStimulus(1'b1, 1'b0, A_STAT, 16'h0000);
        checkOutput("ovf_status2", dbus.dat_i, 16'h1003);

        applyReset();
        checkOutput("flush_status_txd", {15'h0, txd}, 16'h0001);

        // Address just past the block must be ignored.
        applyStimulus(1'b1, 1'b0, A_MISS, 16'h0000);
        checkOutput("miss_rd", dbus.dat_i, 16'h0000);
        applyStimulus(1'b0, 1'b1, A_MISS, 16'h0041);
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("miss_txd_c%0d", k), {15'h0, txd}, 16'h0001);
            tick();
        end
        applyStimulus(1'b1, 1'b0, A_STAT, 16'h0000);
        checkOutput("miss_status", dbus.dat_i, 16'h0004);

        // Reset in the middle of data bit 3 of 0xA5.
        applyStimulus(1'b0, 1'b1, A_BAUD, 16'h0003);
        applyStimulus(1'b0, 1'b1, A_TX,   16'h00A5);
        repeat (18) tick();
        checkOutput("mid_bit3_txd", {15'h0, txd}, 16'h0000);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_rst_txd", {15'h0, txd}, 16'h0001);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();
        applyStimulus(1'b1, 1'b0, A_STAT, 16'h0000);
        checkOutput("post_rst_status", dbus.dat_i, 16'h0004);
        for (int k = 0; k < 50; k++) begin
            if (txd !== 1'b1) checkOutput($sformatf("post_rst_txd_c%0d", k), {15'h0, txd}, 16'h0001);
            tick();
        end
        checkOutput("post_rst_txd", {15'h0, txd}, 16'h0001);
        checkOutput("post_rst_irq", {15'h0, irq}, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
